// File: rtl/five_bit_write_demux.sv
// rtl/five_bit_write_demux.sv - write-back destination demultiplexer with 2-entry FIFO
//
// Accepts (5-bit destination, data) writes on a valid/ready handshake, buffers
// them in a 2-entry FIFO, and presents the oldest write as a one-hot 32-bit
// write-enable plus data for the register bank.
//
// Build option: define WRITE_COUNT_EN to enable the 16-bit commit counter;
// when undefined, commit_cnt is tied to zero.
//
// Parameters:
//   WIDTH        data width of a register write
//   ZERO_PROTECT 1: writes to address 0 are consumed but never raise out_we
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream write handshake
//   in_addr, in_data      destination register number and write data
//   out_valid/out_ready   head-entry handshake toward the register bank
//   out_addr, out_data    head entry (zero when the FIFO is empty)
//   out_we                one-hot write enable, set only on a committing cycle
//   commit_cnt            number of popped writes (WRITE_COUNT_EN only)
module five_bit_write_demux #(
  parameter int WIDTH        = 32,
  parameter bit ZERO_PROTECT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_addr,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_addr,
  output logic [WIDTH-1:0] out_data,
  output logic [31:0]      out_we,
  output logic [15:0]      commit_cnt
);

  logic [4:0]       addr_mem [2];
  logic [WIDTH-1:0] data_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  // Both flags come straight from the registered occupancy, so there is no
  // combinational path from out_ready to in_ready: a full FIFO refuses a push
  // even when it is being drained in the same cycle.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      addr_mem[0] <= '0;
      addr_mem[1] <= '0;
      data_mem[0] <= '0;
      data_mem[1] <= '0;
    end else begin
      if (push) begin
        addr_mem[wr_ptr] <= in_addr;
        data_mem[wr_ptr] <= in_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Head is masked to zero when empty so stale entries never leak out.
  assign out_addr = out_valid ? addr_mem[rd_ptr] : 5'd0;
  assign out_data = out_valid ? data_mem[rd_ptr] : '0;

  // A protected address-0 write still pops (and counts) but enables nothing.
  always_comb begin
    out_we = 32'd0;
    if (pop && !(ZERO_PROTECT && (out_addr == 5'd0))) begin
      out_we = 32'd1 << out_addr;
    end
  end

`ifdef WRITE_COUNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'h0000;
    end else if (pop) begin
      cnt_q <= cnt_q + 16'h0001;
    end
  end

  assign commit_cnt = cnt_q;
`else
  assign commit_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_five_bit_write_demux.sv
// tb/tb_five_bit_write_demux.sv - scoreboard bench for five_bit_write_demux
module tb_five_bit_write_demux;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] we;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [4:0]  out_addr_a, out_addr_b;
  logic [31:0] out_data_a, out_data_b, out_we_a, out_we_b;
  logic [15:0] commit_cnt_a, commit_cnt_b;

  exp_t        qa[$];
  exp_t        qb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] model_cnt = 16'h0000;

  always #5 clk = ~clk;

  // Both instances see identical stimulus; only the address-0 policy differs.
  five_bit_write_demux #(.WIDTH(32), .ZERO_PROTECT(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .in_addr(in_addr), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_addr(out_addr_a), .out_data(out_data_a),
    .out_we(out_we_a), .commit_cnt(commit_cnt_a)
  );

  five_bit_write_demux #(.WIDTH(32), .ZERO_PROTECT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .in_addr(in_addr), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_addr(out_addr_b), .out_data(out_data_b),
    .out_we(out_we_b), .commit_cnt(commit_cnt_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_we(input logic [4:0] a, input bit zp);
    if (zp && a == 5'd0) return 32'd0;
    return 32'd1 << a;
  endfunction

  task automatic enqueue(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a; e.data = d;
    e.we = exp_we(a, 1'b1);
    qa.push_back(e);
    e.we = exp_we(a, 1'b0);
    qb.push_back(e);
  endtask

  // Present one write and hold it until taken; expectation is queued just
  // before the accepting edge.
  task automatic push(input logic [4:0] a, input logic [31:0] d);
    int budget = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_addr = a; in_data = d;
    while (!in_ready_a && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    vectors++;
    if (!in_ready_a) begin
      miscompares++;
      $display("FAIL push_timeout: in_ready stuck at 0 for addr %0d", a);
    end else begin
      enqueue(a, d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_addr  = 5'((i % 31) + 1);
      in_data  = 32'h1000_0000 + 32'(i);
      chk("stream_in_ready", {31'd0, in_ready_a}, 32'd1);
      if (in_ready_a) enqueue(in_addr, in_data);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain_and_check_empty(input string name);
    int budget = 0;
    while ((qa.size() != 0 || qb.size() != 0) && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    chk({name, "_drained"}, qa.size() + qb.size(), 32'd0);
    @(negedge clk);
    chk({name, "_empty_valid"}, {31'd0, out_valid_a}, 32'd0);
    chk({name, "_empty_addr"}, {27'd0, out_addr_a}, 32'd0);
    chk({name, "_empty_data"}, out_data_a, 32'd0);
  endtask

  // Scoreboard monitor: compares every committing cycle against the queues
  // and requires out_we to be zero on every other cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      model_cnt = 16'h0000;
      chk("rst_we_a", out_we_a, 32'd0);
      chk("rst_we_b", out_we_b, 32'd0);
    end else begin
      if (out_valid_a && out_ready) begin
        vectors++;
        if (qa.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_commit_a: addr %0d we %h, expected none", out_addr_a, out_we_a);
        end else begin
          e = qa.pop_front();
          chk("addr_a", {27'd0, out_addr_a}, {27'd0, e.addr});
          chk("data_a", out_data_a, e.data);
          chk("we_a", out_we_a, e.we);
`ifdef WRITE_COUNT_EN
          chk("commit_cnt", {16'd0, commit_cnt_a}, {16'd0, model_cnt});
`else
          chk("commit_cnt", {16'd0, commit_cnt_a}, 32'd0);
`endif
          model_cnt = model_cnt + 16'd1;
        end
      end else begin
        chk("idle_we_a", out_we_a, 32'd0);
      end
      if (out_valid_b && out_ready) begin
        vectors++;
        if (qb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_commit_b: addr %0d we %h, expected none", out_addr_b, out_we_b);
        end else begin
          e = qb.pop_front();
          chk("addr_b", {27'd0, out_addr_b}, {27'd0, e.addr});
          chk("we_b", out_we_b, e.we);
        end
      end else begin
        chk("idle_we_b", out_we_b, 32'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_addr = 5'd5; in_data = 32'hFFFF_FFFF; out_ready = 1'b1;

    // Reset state with a request pending on the input.
    #12;
    chk("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready_a}, 32'd1);
    chk("rst_out_we", out_we_a, 32'd0);
    chk("rst_out_addr", {27'd0, out_addr_a}, 32'd0);
    chk("rst_out_data", out_data_a, 32'd0);
    chk("rst_commit_cnt", {16'd0, commit_cnt_a}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Single write: visible right after the accepting edge, then empty.
    push(5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("latency_valid", {31'd0, out_valid_a}, 32'd1);
    chk("latency_we", out_we_a, 32'h0000_0020);
    chk("latency_data", out_data_a, 32'hDEAD_BEEF);
    drain_and_check_empty("single");

    // Back-pressure: two pushes fill the FIFO, a third is refused.
    @(posedge clk); #1;
    out_ready = 1'b0;
    push(5'd3, 32'h0000_0333);
    push(5'd7, 32'h0000_0777);
    @(posedge clk); #1;
    in_valid = 1'b1; in_addr = 5'd9; in_data = 32'h0000_0999;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_in_ready", {31'd0, in_ready_a}, 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain_and_check_empty("backpressure");

    // Address 0: protected instance commits silently, other writes bit 0.
    push(5'd0, 32'h0000_00AA);
    drain_and_check_empty("zero");

    // Steady stream through the FIFO.
    stream(40);
    drain_and_check_empty("stream");

    // Reset with two entries pending: they must never be written.
    @(posedge clk); #1;
    out_ready = 1'b0;
    push(5'd4, 32'h0000_0044);
    push(5'd9, 32'h0000_0099);
    @(negedge clk);
    chk("pre_rst_full", {31'd0, in_ready_a}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    out_ready = 1'b1;
    qa.delete();
    qb.delete();
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid_a}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready_a}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("post_rst_valid", {31'd0, out_valid_a}, 32'd0);
    chk("post_rst_cnt", {16'd0, commit_cnt_a}, 32'd0);

`ifdef WRITE_COUNT_EN
    // 65536 commits from zero bring the counter through 0xFFFF back to 0.
    stream(65535);
    drain_and_check_empty("wrap_pre");
    chk("cnt_ffff", {16'd0, commit_cnt_a}, 32'h0000_FFFF);
    push(5'd2, 32'h0000_0002);
    drain_and_check_empty("wrap");
    chk("cnt_wrap", {16'd0, commit_cnt_a}, 32'h0000_0000);
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
